// File: rtl/direction_logic.sv
// Snake travel-direction register: synchronises four button levels, drops the
// reversal request, resolves UP > DOWN > LEFT > RIGHT and registers the result.
module direction_logic #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [1:0] RESET_DIR   = 2'b11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic [1:0] directionOut
);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  // Button vector bit (3 - code) carries the request for direction code.
  logic [3:0] btn_raw;
  logic [3:0] btn_sync;
  logic [3:0] req_filt;
  logic [1:0] opp_dir;
  logic [1:0] dir_d;
  logic [1:0] dir_q;

  assign btn_raw = {up, down, left, right};

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign btn_sync = btn_raw;
    end else begin : g_sync
      logic [3:0] sync_q [SYNC_STAGES];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b0000;
        end else begin
          sync_q[0] <= btn_raw;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end

      assign btn_sync = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_comb begin
    opp_dir  = dir_q ^ 2'b01;
    req_filt = btn_sync & ~(4'b1000 >> opp_dir);
    dir_d    = dir_q;
    if (req_filt[3])      dir_d = DIR_UP;
    else if (req_filt[2]) dir_d = DIR_DOWN;
    else if (req_filt[1]) dir_d = DIR_LEFT;
    else if (req_filt[0]) dir_d = DIR_RIGHT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dir_q <= RESET_DIR;
    else     dir_q <= dir_d;
  end

  assign directionOut = dir_q;

endmodule

// File: tb/tb_direction_logic.sv
// Bench for direction_logic: directed scenarios on a 2-stage instance plus a
// 0-stage instance, and randomized button traffic checked against a reference.
module tb_direction_logic;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [1:0] dir2;
  logic [1:0] dir0;
  logic [3:0] btn;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign btn = {up, down, left, right};

  direction_logic #(.SYNC_STAGES(2), .RESET_DIR(2'b11)) dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
    .directionOut(dir2)
  );

  direction_logic #(.SYNC_STAGES(0), .RESET_DIR(2'b11)) dut0 (
    .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
    .directionOut(dir0)
  );

  // Reference: walk the directions in priority order, take the first pressed
  // one that is not the reverse of the current heading.
  function automatic logic [1:0] resolve(input logic [1:0] cur, input logic [3:0] b);
    logic [1:0] order [4];
    logic       pressed [4];
    order   = '{2'd0, 2'd1, 2'd2, 2'd3};
    pressed = '{b[3], b[2], b[1], b[0]};
    for (int k = 0; k < 4; k++) begin
      if (pressed[k] && (order[k] != (cur ^ 2'b01))) return order[k];
    end
    return cur;
  endfunction

  logic [1:0] m2 = 2'b11;
  logic [1:0] m0 = 2'b11;
  logic [3:0] hist2 [$] = '{4'b0000, 4'b0000};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m2 <= 2'b11;
      m0 <= 2'b11;
      hist2 = '{4'b0000, 4'b0000};
    end else begin
      m2 <= resolve(m2, hist2.pop_front());
      hist2.push_back(btn);
      m0 <= resolve(m0, btn);
    end
  end

  task automatic set_btn(input logic [3:0] b);
    {up, down, left, right} = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_btn(4'b0000);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_btn(4'b0110);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      tests_run++;
      if (dir2 !== 2'b11) begin
        tests_failed++;
        $display("FAIL reset_hold dut got %b expected 11", dir2);
      end
      tests_run++;
      if (dir0 !== 2'b11) begin
        tests_failed++;
        $display("FAIL reset_hold dut0 got %b expected 11", dir0);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (dir2 !== 2'b11) begin
      tests_failed++;
      $display("FAIL reset_first_edge dut got %b expected 11", dir2);
    end
    tests_run++;
    if (dir0 !== 2'b01) begin
      tests_failed++;
      $display("FAIL reset_first_edge dut0 got %b expected 01", dir0);
    end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    tests_run++;
    if (dir2 !== 2'b11) begin
      tests_failed++;
      $display("FAIL simul_edge2 got %b expected 11", dir2);
    end
    @(negedge clk);
    tests_run++;
    if (dir2 !== 2'b01) begin
      tests_failed++;
      $display("FAIL simul_edge3 got %b expected 01", dir2);
    end
    repeat (4) begin
      @(negedge clk);
      tests_run++;
      if (dir2 !== 2'b01) begin
        tests_failed++;
        $display("FAIL simul_hold got %b expected 01", dir2);
      end
    end
  endtask

  task automatic test_reversal();
    do_reset();
    set_btn(4'b0010);
    repeat (8) begin
      @(negedge clk);
      tests_run++;
      if (dir2 !== 2'b11) begin
        tests_failed++;
        $display("FAIL reversal_left got %b expected 11", dir2);
      end
    end
    set_btn(4'b1000);
    repeat (3) @(negedge clk);
    tests_run++;
    if (dir2 !== 2'b00) begin
      tests_failed++;
      $display("FAIL reversal_up got %b expected 00", dir2);
    end
    set_btn(4'b0100);
    repeat (8) begin
      @(negedge clk);
      tests_run++;
      if (dir2 !== 2'b00) begin
        tests_failed++;
        $display("FAIL reversal_down got %b expected 00", dir2);
      end
    end
  endtask

  task automatic test_priority();
    logic [3:0] steps [5];
    logic [1:0] expect_dir [5];
    steps      = '{4'b0010, 4'b1111, 4'b0010, 4'b0100, 4'b0011};
    expect_dir = '{2'b10,   2'b00,   2'b10,   2'b01,   2'b10};
    for (int s = 0; s < 5; s++) begin
      set_btn(steps[s]);
      repeat (3) @(negedge clk);
      tests_run++;
      if (dir2 !== expect_dir[s]) begin
        tests_failed++;
        $display("FAIL priority_step%0d btn=%b got %b expected %b", s, steps[s], dir2, expect_dir[s]);
      end
    end
  endtask

  task automatic test_async_reset();
    set_btn(4'b0100);
    repeat (3) @(negedge clk);
    tests_run++;
    if (dir2 !== 2'b01) begin
      tests_failed++;
      $display("FAIL async_pre got %b expected 01", dir2);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    tests_run++;
    if (dir2 !== 2'b11) begin
      tests_failed++;
      $display("FAIL async_immediate got %b expected 11", dir2);
    end
    #2 rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      tests_run++;
      if (dir2 !== ((e == 3) ? 2'b01 : 2'b11)) begin
        tests_failed++;
        $display("FAIL async_relatch edge%0d got %b expected %b", e, dir2, (e == 3) ? 2'b01 : 2'b11);
      end
    end
  endtask

  task automatic test_latency();
    do_reset();
    set_btn(4'b1000);
    @(negedge clk);
    set_btn(4'b0000);
    tests_run++;
    if (dir2 !== 2'b11) begin
      tests_failed++;
      $display("FAIL latency_edge1 got %b expected 11", dir2);
    end
    tests_run++;
    if (dir0 !== 2'b00) begin
      tests_failed++;
      $display("FAIL latency_nosync_edge1 got %b expected 00", dir0);
    end
    @(negedge clk);
    tests_run++;
    if (dir2 !== 2'b11) begin
      tests_failed++;
      $display("FAIL latency_edge2 got %b expected 11", dir2);
    end
    @(negedge clk);
    tests_run++;
    if (dir2 !== 2'b00) begin
      tests_failed++;
      $display("FAIL latency_edge3 got %b expected 00", dir2);
    end
    repeat (4) begin
      @(negedge clk);
      tests_run++;
      if (dir2 !== 2'b00 || dir0 !== 2'b00) begin
        tests_failed++;
        $display("FAIL latency_hold got %b/%b expected 00/00", dir2, dir0);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      tests_run++;
      if (dir2 !== m2) begin
        tests_failed++;
        $display("FAIL random_sync2 cycle %0d got %b expected %b", c, dir2, m2);
      end
      tests_run++;
      if (dir0 !== m0) begin
        tests_failed++;
        $display("FAIL random_sync0 cycle %0d got %b expected %b", c, dir0, m0);
      end
      if ($urandom_range(0, 3) == 0) set_btn(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_reversal();
    test_priority();
    test_async_reset();
    test_latency();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/direction_logic.md
Name: direction_logic

Overview:
- Holds the current travel direction for the snake game core.
- Takes four raw push-button levels (up/down/left/right), synchronises them and resolves simultaneous presses by fixed priority.
- Rejects 180-degree reversals and registers the result as a 2-bit direction code.
- Downstream movement/collision logic consumes the registered direction code.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchroniser stages on each button input (0 = no synchroniser, inputs used directly).
- RESET_DIR, 2'b11, direction loaded on reset (RIGHT).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- up  input  1  up button level, active-high, asynchronous to clk.
- down  input  1  down button level, active-high.
- left  input  1  left button level, active-high.
- right  input  1  right button level, active-high.
- directionOut  output  2  registered current direction: UP=2'b00, DOWN=2'b01, LEFT=2'b10, RIGHT=2'b11.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset:
  - While rst=1, directionOut=RESET_DIR (2'b11) immediately, independent of clk.
  - All synchroniser flops clear to 0.
  - Release of rst takes effect at the next rising clk edge; no input is acted on during reset.
- Synchroniser:
  - Each button passes through SYNC_STAGES flops clocked by clk.
  - The synchronised value feeds the decision logic.
- Level-sensitive requests:
  - A button held high requests its direction every cycle; no edge detection.
  - A held button therefore re-requests continuously. This is harmless because re-requesting the current direction leaves it unchanged.
- Opposite pairs: UP/DOWN, LEFT/RIGHT. Opposite of code d is d XOR 2'b01.
- Reversal filter: a request equal to the opposite of the current directionOut is discarded before priority resolution.
- Priority among the surviving requests: UP > DOWN > LEFT > RIGHT. The highest surviving request becomes the next direction.
- No surviving request (no buttons, or only the reversal button): directionOut holds.
- Request equal to the current direction: directionOut holds (no glitch, same value re-registered).
- All four pressed: the reversal is filtered, then the highest remaining wins. Example: current RIGHT, all pressed -> UP.
- Both buttons of an opposite pair pressed, one of them the reversal: the non-reversal one is a valid request. Example: current UP, up+down pressed -> stays UP.
- Latency: a button level stable before rising edge k yields the updated directionOut after rising edge k+SYNC_STAGES. Default: 3rd rising edge counting the first sampling edge.
- Update rate: at most one direction change per clock. The reversal check always uses the registered directionOut, so two presses in consecutive cycles may execute a 90+90 turn (e.g. RIGHT->UP->LEFT). This is acceptable.
- Reset mid-operation: directionOut returns to RESET_DIR asynchronously. Synchroniser contents are discarded; buttons still held after release are re-sampled from scratch with full latency.
- Outputs are purely registered; no combinational path from buttons to directionOut.

Test Plan:
1. Reset: rst=1 for 2 cycles with down=1, left=1 -> directionOut=2'b11 throughout reset. Same value on first edge after release.
2. Simultaneous down=1, left=1 held after reset (from RIGHT):
   - DOWN beats LEFT -> directionOut=2'b01 on the 3rd rising edge after release, SYNC_STAGES=2.
   - Stays 2'b01 while both remain held.
3. Reversal rejection:
   - From RIGHT, assert left only -> directionOut stays 2'b11 indefinitely.
   - Then assert up -> 2'b00.
   - Then assert down only -> stays 2'b00.
4. Priority sweep from LEFT (2'b10):
   - All four buttons pressed -> right filtered, up wins -> 2'b00.
   - From DOWN, assert left+right -> LEFT wins -> 2'b10.
5. Async reset mid-run: directionOut=2'b01, pulse rst=1 for 3 ms between clock edges -> directionOut=2'b11 before the next clock edge. Held buttons take effect again only after full sync latency.
6. Latency/no-glitch:
   - Single-cycle 10 ms pulse on up from RIGHT -> directionOut=2'b00 exactly SYNC_STAGES+1 edges after sampling, then holds after release.
   - Repeat with SYNC_STAGES=0 -> change on the next edge.
